pipe_stage_regs: RTL
====================

# pipe_stage_regs

Pipeline register set for the five-stage RISC-V core: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It is the consumer of the hazard unit's stall and flush outputs. It is also the producer of the register-index and write-enable fields the hazard unit inspects: Rs1E, Rs2E, RdE, ResultSrcE0, RdM, RdW, RegWriteM and RegWriteW. Each stage carries a valid bit, and a retired-instruction counter gives the bench an architectural progress measure.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- RESET_PC, 32'h0000_0000, PCF value after reset
- NOP_INSTR, 32'h0000_0013, instruction injected into IF/ID on flush/reset (addi x0,x0,0)

Ports (one clock, clk; reset is asynchronous and active-high, named reset):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- StallF  in  1  hold PC register
- StallD  in  1  hold IF/ID register
- FlushD  in  1  bubble IF/ID
- FlushE  in  1  bubble ID/EX
- PCNextF  in  XLEN  next PC from fetch mux
- InstrF  in  32  fetched instruction
- PCPlus4F  in  XLEN  PCF+4
- Rs1D, Rs2D, RdD  in  5 each  decoded register indices
- RegWriteD  in  1  decode register-write enable
- MemWriteD  in  1  decode store enable
- ResultSrcD  in  2  decode result select (bit 0 = load)
- PCF  out  XLEN  current fetch PC
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents
- Rs1E, Rs2E, RdE  out  5 each  ID/EX indices
- RegWriteE, MemWriteE  out  1 each; ResultSrcE  out  2; PCE  out  XLEN
- ResultSrcE0  out  1  = ResultSrcE[0]
- RdM  out  5; RegWriteM, MemWriteM  out  1 each; ResultSrcM  out  2
- RdW  out  5; RegWriteW  out  1; ResultSrcW  out  2
- ValidD, ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
- RetireCount  out  32  instructions that have left MEM/WB valid

## Operation
- Every register updates at the same edge. Per-register priority is reset > flush > stall > load.
- PC: if StallF, hold; else PCF <= PCNextF.
- IF/ID: FlushD loads InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. Else StallD holds. Else it loads InstrF, PCF, PCPlus4F and ValidD=1.
- FlushD and StallD together: the flush wins.
- ID/EX: FlushE loads a bubble with Rs1E=Rs2E=RdE=0, RegWriteE=MemWriteE=0, ResultSrcE=0, PCE=0, ValidE=0. Else it loads the D-stage fields and ValidE=ValidD.
- ID/EX has no stall input. The load-use case (StallF, StallD and FlushE all asserted) holds PC and IF/ID and inserts one bubble into EX.
- EX/MEM and MEM/WB always advance, copying the previous stage unchanged, including the valid bit.
- A bubble never carries RegWriteX=1 or MemWriteX=1. An invalid stage therefore can never trigger forwarding or a write.
- RetireCount increments by 1 on every edge where ValidW=1 (sampled before the edge). It wraps from 0xFFFF_FFFF to 0.
- Bubbles never count.

## Timing
- Reset values:
  - PCF=RESET_PC; InstrD=NOP_INSTR.
  - PCD, PCPlus4D and PCE are 0.
  - All indices 0; all RegWrite/MemWrite/ResultSrc 0.
  - All Valid 0; RetireCount 0.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge.
- After reset deasserts, PCF advances at the first rising edge.
- Latency: one cycle per stage. With no stalls, an instruction fetched at edge N appears in D after N+1, E after N+2, M after N+3, W after N+4. It counts at edge N+5.
- All outputs are registered; no combinational path from any input to any output.
- StallD held for k cycles keeps InstrD constant for k cycles. E receives one copy per cycle unless FlushE is asserted.
- Flush is not sticky. Each asserted cycle inserts exactly one bubble.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle with a non-empty pipe.
  - Required: PCF=0, InstrD=0x00000013, all Valid=0 and RetireCount=0, all before the next edge.
- **Free flow:** PCNextF=PCF+4, five distinct InstrF values, RdD=1..5, RegWriteD=1.
  - Required: RdW shows 1..5 on consecutive cycles, 4 edges after each fetch.
  - Required: RetireCount=5 after the last one retires.
- **Load-use:** ResultSrcD=2'b01, RdD=4, then StallF=StallD=FlushE=1 for one cycle.
  - Required: PCF and InstrD unchanged that cycle.
  - Required: E holds a bubble with RdE=0, RegWriteE=0, ValidE=0.
  - Required: the stalled instruction enters E on the following edge.
- **Branch flush:** FlushD=FlushE=1 for one cycle.
  - Required: InstrD=NOP, ValidD=0, ValidE=0.
  - Required: RetireCount ends 2 lower than the no-flush run.
- **Priority:** FlushD=1 and StallD=1 together.
  - Required: InstrD=NOP and ValidD=0; the flush wins.
- **Counter wrap:** force RetireCount to 0xFFFF_FFFF via the bench hierarchy, then retire one valid instruction.
  - Required: RetireCount=0.

Source files
------------

// File: rtl/pipe_stage_regs_if.sv
// Signal bundle between the hazard/datapath side and the five-stage pipeline registers.
// The master side drives fetch/decode fields and hazard controls; the slave side returns stage contents.
interface pipe_stage_regs_if #(
  parameter int unsigned XLEN = 32
);
  logic            StallF;
  logic            StallD;
  logic            FlushD;
  logic            FlushE;
  logic [XLEN-1:0] PCNextF;
  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCPlus4F;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic            RegWriteD;
  logic            MemWriteD;
  logic [1:0]      ResultSrcD;

  logic [XLEN-1:0] PCF;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [XLEN-1:0] PCE;
  logic            ResultSrcE0;
  logic [4:0]      RdM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdW;
  logic            RegWriteW;
  logic [1:0]      ResultSrcW;
  logic            ValidD;
  logic            ValidE;
  logic            ValidM;
  logic            ValidW;
  logic [31:0]     RetireCount;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD,
    input  PCF, InstrD, PCD, PCPlus4D, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE,
           ResultSrcE, PCE, ResultSrcE0, RdM, RegWriteM, MemWriteM, ResultSrcM,
           RdW, RegWriteW, ResultSrcW, ValidD, ValidE, ValidM, ValidW, RetireCount
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCNextF, InstrF, PCPlus4F,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, ResultSrcD,
    output PCF, InstrD, PCD, PCPlus4D, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE,
           ResultSrcE, PCE, ResultSrcE0, RdM, RegWriteM, MemWriteM, ResultSrcM,
           RdW, RegWriteW, ResultSrcW, ValidD, ValidE, ValidM, ValidW, RetireCount
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers with per-stage valid bits and a retire counter.
// Priority per register: reset > flush > stall > load.
module pipe_stage_regs #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_regs_if.slave  bus
);

  logic [31:0] retireCount;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.PCF <= RESET_PC;
    end else if (!bus.StallF) begin
      bus.PCF <= bus.PCNextF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.InstrD   <= NOP_INSTR;
      bus.PCD      <= '0;
      bus.PCPlus4D <= '0;
      bus.ValidD   <= 1'b0;
    end else if (bus.FlushD) begin
      bus.InstrD   <= NOP_INSTR;
      bus.PCD      <= '0;
      bus.PCPlus4D <= '0;
      bus.ValidD   <= 1'b0;
    end else if (!bus.StallD) begin
      bus.InstrD   <= bus.InstrF;
      bus.PCD      <= bus.PCF;
      bus.PCPlus4D <= bus.PCPlus4F;
      bus.ValidD   <= 1'b1;
    end
  end

  // Write enables are qualified by ValidD so a bubble can never forward or write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.Rs1E       <= '0;
      bus.Rs2E       <= '0;
      bus.RdE        <= '0;
      bus.RegWriteE  <= 1'b0;
      bus.MemWriteE  <= 1'b0;
      bus.ResultSrcE <= '0;
      bus.PCE        <= '0;
      bus.ValidE     <= 1'b0;
    end else if (bus.FlushE) begin
      bus.Rs1E       <= '0;
      bus.Rs2E       <= '0;
      bus.RdE        <= '0;
      bus.RegWriteE  <= 1'b0;
      bus.MemWriteE  <= 1'b0;
      bus.ResultSrcE <= '0;
      bus.PCE        <= '0;
      bus.ValidE     <= 1'b0;
    end else begin
      bus.Rs1E       <= bus.Rs1D;
      bus.Rs2E       <= bus.Rs2D;
      bus.RdE        <= bus.RdD;
      bus.RegWriteE  <= bus.RegWriteD & bus.ValidD;
      bus.MemWriteE  <= bus.MemWriteD & bus.ValidD;
      bus.ResultSrcE <= bus.ResultSrcD;
      bus.PCE        <= bus.PCD;
      bus.ValidE     <= bus.ValidD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.RdM        <= '0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.ValidM     <= 1'b0;
      bus.RdW        <= '0;
      bus.RegWriteW  <= 1'b0;
      bus.ResultSrcW <= '0;
      bus.ValidW     <= 1'b0;
    end else begin
      bus.RdM        <= bus.RdE;
      bus.RegWriteM  <= bus.RegWriteE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.ValidM     <= bus.ValidE;
      bus.RdW        <= bus.RdM;
      bus.RegWriteW  <= bus.RegWriteM;
      bus.ResultSrcW <= bus.ResultSrcM;
      bus.ValidW     <= bus.ValidM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retireCount <= '0;
    end else if (bus.ValidW) begin
      retireCount <= retireCount + 32'd1;
    end
  end

  assign bus.RetireCount = retireCount;
  assign bus.ResultSrcE0 = bus.ResultSrcE[0];

endmodule
